// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory handshake, decode handshake and
// the decode/redirect side-band the fetch unit consumes.
interface instr_fetch_if #(parameter int CNT_W = 32);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ready;
  logic [31:0]      imem_rdata;
  logic [31:0]      instruction;
  logic             instr_valid;
  logic             instr_ready;
  logic             is_jump;
  logic             is_branch;
  logic             branch_taken;
  logic [25:0]      addr26;
  logic [15:0]      imm16;
  logic             flush;
  logic [31:0]      flush_pc;
  logic [31:0]      pc;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc, instr_count,
    input  imem_ready, imem_rdata, instr_ready, is_jump, is_branch,
           branch_taken, addr26, imm16, flush, flush_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc, instr_count,
    output imem_ready, imem_rdata, instr_ready, is_jump, is_branch,
           branch_taken, addr26, imm16, flush, flush_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch for the single-cycle MIPS core: IDLE -> FETCH -> HOLD loop,
// next-PC from decode's jump/branch results, flush/redirect with deferred apply.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fpend_q, fpend_d;
  logic [31:0]      fpc_q, fpc_d;

  logic [31:0] pc4, jump_tgt, br_off, next_pc;

  assign pc4      = pc_q + 32'd4;
  assign jump_tgt = {pc4[31:28], bus.addr26, 2'b00};
  assign br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};

  always_comb begin
    next_pc = pc4;
    if (bus.is_jump)                         next_pc = jump_tgt;
    else if (bus.is_branch && bus.branch_taken) next_pc = pc4 + br_off;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
      fpc_q   <= fpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    fpend_d = fpend_q;
    fpc_d   = fpc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) pc_d = bus.flush_pc;
        state_d = FETCH;
      end
      FETCH: begin
        // A request in flight must complete; a flush arriving mid-request is
        // parked and applied when the (discarded) response lands.
        if (bus.imem_ready) begin
          if (bus.flush) begin
            pc_d    = bus.flush_pc;
            fpend_d = 1'b0;
          end else if (fpend_q) begin
            pc_d    = fpc_q;
            fpend_d = 1'b0;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = HOLD;
          end
        end else if (bus.flush) begin
          fpend_d = 1'b1;
          fpc_d   = bus.flush_pc;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          pc_d    = bus.flush_pc;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.pc          = pc_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC scoreboard and a synthetic memory.
module tb_instr_fetch;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] sb[$];
  logic [31:0] addrs[$];
  logic [7:0]  vpat;
  logic [31:0] c0;

  instr_fetch_if #(.CNT_W(32)) f();

  instr_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (f.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign f.imem_rdata = mem_word(f.imem_addr);

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic j, b, t,
                                             input logic [25:0] a26, input logic [15:0] i16);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (j) return {p4[31:28], a26, 2'b00};
    if (b && t) return p4 + (32'($signed(i16)) << 2);
    return p4;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: update the scoreboard for the event about to be clocked in,
  // then compare any held instruction at the following falling edge.
  task automatic cycle();
    logic [31:0] nxt;
    if (!reset) begin
      if (f.flush) begin
        sb.delete();
        sb.push_back(f.flush_pc);
      end else if (f.instr_valid && f.instr_ready && sb.size() > 0) begin
        nxt = model_next(sb[0], f.is_jump, f.is_branch, f.branch_taken, f.addr26, f.imm16);
        void'(sb.pop_front());
        sb.push_back(nxt);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (f.instr_valid) begin
      chk("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        chk("held_pc", f.pc, sb[0]);
        chk("held_instr", f.instruction, mem_word(sb[0]));
      end
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!f.instr_valid && n < 10) begin
      cycle();
      n++;
    end
    chk("valid_timeout", 32'(f.instr_valid), 32'd1);
  endtask

  task automatic go(input logic [31:0] target, input logic j, b, t,
                    input logic [25:0] a26, input logic [15:0] i16, input logic [31:0] exp);
    logic [31:0] cnt0;
    f.flush = 1'b1;
    f.flush_pc = target;
    cycle();
    f.flush = 1'b0;
    wait_valid();
    cnt0 = f.instr_count;
    f.is_jump = j; f.is_branch = b; f.branch_taken = t; f.addr26 = a26; f.imm16 = i16;
    f.instr_ready = 1'b1;
    cycle();
    f.instr_ready = 1'b0;
    f.is_jump = 1'b0; f.is_branch = 1'b0; f.branch_taken = 1'b0; f.addr26 = '0; f.imm16 = '0;
    chk("next_fetch_addr", f.imem_addr, exp);
    chk("next_fetch_req", 32'(f.imem_req), 32'd1);
    chk("count_inc", f.instr_count, cnt0 + 32'd1);
    wait_valid();
  endtask

  initial begin
    reset = 1'b1;
    f.imem_ready = 1'b0; f.instr_ready = 1'b0;
    f.is_jump = 1'b0; f.is_branch = 1'b0; f.branch_taken = 1'b0;
    f.addr26 = '0; f.imm16 = '0; f.flush = 1'b0; f.flush_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(f.imem_req), 32'd0);
    chk("rst_addr", f.imem_addr, 32'h0);
    chk("rst_valid", 32'(f.instr_valid), 32'd0);
    chk("rst_instr", f.instruction, 32'h0);
    chk("rst_count", f.instr_count, 32'h0);

    // Streaming from reset: memory always ready, decode always accepting.
    reset = 1'b0;
    f.imem_ready = 1'b1;
    f.instr_ready = 1'b1;
    sb.push_back(32'h0);
    vpat = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      vpat = {vpat[6:0], f.instr_valid};
      if (f.imem_req) addrs.push_back(f.imem_addr);
    end
    chk("stream_nreq", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < addrs.size()) chk("stream_addr", addrs[i], 32'(4 * i));
    chk("stream_valid_pattern", 32'(vpat), 32'h55);
    cycle();
    chk("stream_count", f.instr_count, 32'd4);
    f.instr_ready = 1'b0;

    go(32'h0040_0010, 1'b1, 1'b0, 1'b0, 26'h0100003, 16'h0000, 32'h0040_000C);
    go(32'h0000_0100, 1'b0, 1'b1, 1'b1, 26'h0,       16'hFFFE, 32'h0000_00FC);
    go(32'h0000_0100, 1'b0, 1'b1, 1'b0, 26'h0,       16'hFFFE, 32'h0000_0104);
    go(32'h0000_1000, 1'b0, 1'b1, 1'b1, 26'h0,       16'h0010, 32'h0000_1044);
    go(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 26'h0,       16'h0000, 32'h0000_0000);
    go(32'h0000_0100, 1'b1, 1'b1, 1'b1, 26'h0000080, 16'hFFFE, 32'h0000_0200);
    go(32'h0000_0103, 1'b0, 1'b0, 1'b0, 26'h0,       16'h0000, 32'h0000_0107);

    // Flush while a slow request is outstanding: the response is dropped.
    c0 = f.instr_count;
    f.imem_ready = 1'b0;
    f.flush = 1'b1; f.flush_pc = 32'h20;
    cycle();
    chk("slow_addr0", f.imem_addr, 32'h20);
    f.instr_ready = 1'b1;
    f.flush_pc = 32'h90;
    cycle();
    chk("slow_addr1", f.imem_addr, 32'h20);
    f.flush_pc = 32'h80;
    cycle();
    chk("slow_addr2", f.imem_addr, 32'h20);
    f.flush = 1'b0;
    cycle();
    chk("slow_addr3", f.imem_addr, 32'h20);
    chk("slow_req", 32'(f.imem_req), 32'd1);
    f.imem_ready = 1'b1;
    cycle();
    chk("redirect_addr", f.imem_addr, 32'h80);
    chk("redirect_valid", 32'(f.instr_valid), 32'd0);
    chk("redirect_count", f.instr_count, c0);
    f.instr_ready = 1'b0;
    wait_valid();

    // Flush beats acceptance in the same cycle.
    c0 = f.instr_count;
    f.instr_ready = 1'b1;
    f.flush = 1'b1; f.flush_pc = 32'h300;
    cycle();
    f.flush = 1'b0; f.instr_ready = 1'b0;
    chk("hold_flush_count", f.instr_count, c0);
    chk("hold_flush_addr", f.imem_addr, 32'h300);
    chk("hold_flush_valid", 32'(f.instr_valid), 32'd0);
    wait_valid();

    // Asynchronous reset in the middle of a fetch.
    c0 = f.instr_count;
    f.imem_ready = 1'b0;
    f.instr_ready = 1'b1;
    cycle();
    f.instr_ready = 1'b0;
    chk("pre_rst_req", 32'(f.imem_req), 32'd1);
    chk("pre_rst_count", f.instr_count, c0 + 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_req", 32'(f.imem_req), 32'd0);
    chk("async_addr", f.imem_addr, 32'h0);
    chk("async_valid", 32'(f.instr_valid), 32'd0);
    chk("async_instr", f.instruction, 32'h0);
    chk("async_count", f.instr_count, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    sb.push_back(32'h0);
    f.imem_ready = 1'b1;
    cycle();
    chk("post_rst_req", 32'(f.imem_req), 32'd1);
    chk("post_rst_addr", f.imem_addr, 32'h0);
    wait_valid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
